// File: rtl/prog_seq_pkg.sv
// Shared constants and types for the microcode sequencer: opcodes, FSM state
// encoding and the datapath field layout of a command word.
package prog_seq_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned OP_W       = 6;
  localparam int unsigned OP_LSB     = 26;
  localparam int unsigned DP_W       = 26;
  localparam int unsigned HOLD_W     = OP_W;
  localparam int unsigned PE_W       = 11;
  localparam int unsigned RAM_ADDR_W = 7;

  localparam logic [OP_W-1:0] OP_HALT      = 6'h00;
  localparam logic [OP_W-1:0] OP_ISSUE_MAX = 6'h2F;
  localparam logic [OP_W-1:0] OP_JUMP      = 6'h3C;
  localparam logic [OP_W-1:0] OP_ENDLOOP   = 6'h3D;
  localparam logic [OP_W-1:0] OP_LOOP      = 6'h3E;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_HOLD = 3'b100
  } state_t;

  // Datapath fields in rom_q[DP_W-1:0], MSB first
  typedef struct packed {
    logic                  ram_b_w;
    logic [RAM_ADDR_W-1:0] ram_b_addr;
    logic [RAM_ADDR_W-1:0] ram_a_addr;
    logic [PE_W-1:0]       pe_ctrl;
  } dp_fields_t;

  function automatic logic is_issue(input logic [OP_W-1:0] op);
    return (op != OP_HALT) && (op <= OP_ISSUE_MAX);
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Host control, command ROM and datapath signals of the sequencer.
// master = host/ROM side, slave = sequencer.
interface prog_sequencer_if;
  import prog_seq_pkg::*;

  logic                  start;
  logic [ADDR_W-1:0]     entry_addr;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ADDR_W-1:0]     rom_addr;
  logic [WORD_W-1:0]     rom_q;
  logic [RAM_ADDR_W-1:0] ram_a_addr;
  logic [RAM_ADDR_W-1:0] ram_b_addr;
  logic                  ram_b_w;
  logic [PE_W-1:0]       pe_ctrl;

  modport master (
    output start, entry_addr, rom_q,
    input  busy, done, err, rom_addr, ram_a_addr, ram_b_addr, ram_b_w, pe_ctrl
  );

  modport slave (
    input  start, entry_addr, rom_q,
    output busy, done, err, rom_addr, ram_a_addr, ram_b_addr, ram_b_w, pe_ctrl
  );

endinterface

// File: rtl/seq_loop_stack.sv
// LIFO of {loop body address, remaining iterations} for nested counted loops.
// Only one of push/pop/dec_top is expected per cycle; clear empties the stack.
module seq_loop_stack
  import prog_seq_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              dec_top,
  input  logic [ADDR_W-1:0] push_body,
  input  logic [CNT_W-1:0]  push_rem,
  output logic [ADDR_W-1:0] top_body,
  output logic [CNT_W-1:0]  top_rem,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CNT_PW = $clog2(LOOP_DEPTH + 1);
  localparam int unsigned IDX_W  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  logic [ADDR_W-1:0] body_q [LOOP_DEPTH];
  logic [CNT_W-1:0]  rem_q  [LOOP_DEPTH];
  logic [CNT_PW-1:0] cnt_q;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  assign top_idx  = IDX_W'(cnt_q - CNT_PW'(1));
  assign push_idx = IDX_W'(cnt_q);
  assign full     = (cnt_q == CNT_PW'(LOOP_DEPTH));
  assign empty    = (cnt_q == '0);
  assign top_body = body_q[top_idx];
  assign top_rem  = rem_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      cnt_q <= cnt_q + CNT_PW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_PW'(1);
    end
  end

  // Entry storage needs no reset: only slots below cnt_q are ever read.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      body_q[push_idx] <= push_body;
      rem_q[push_idx]  <= push_rem;
    end else if (dec_top && !empty) begin
      rem_q[top_idx] <= rem_q[top_idx] - CNT_W'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Microcode sequencer: runs a command-ROM program from a host entry address.
// Define PROG_SEQ_LOOP_EN to build the LOOP/ENDLOOP instructions and loop stack.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int unsigned LOOP_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  prog_sequencer_if.slave bus
);

  if (LOOP_DEPTH < 1 || CNT_W < 1 || CNT_W > DP_W) begin : g_param_check
    $error("prog_sequencer: LOOP_DEPTH must be >= 1 and CNT_W in 1..26");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [HOLD_W-1:0] hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [OP_W-1:0]   op;
  logic [ADDR_W-1:0] addr_inc;
  logic              issue_c;
  dp_fields_t        dp;

  assign op       = bus.rom_q[WORD_W-1:OP_LSB];
  assign addr_inc = rom_addr_q + ADDR_W'(1);

  // Datapath fields pass through only while an ISSUE word is executing
  assign issue_c = (state_q != ST_IDLE) && is_issue(op);
  assign dp      = issue_c ? dp_fields_t'(bus.rom_q[DP_W-1:0]) : '0;

  assign bus.pe_ctrl    = dp.pe_ctrl;
  assign bus.ram_a_addr = dp.ram_a_addr;
  assign bus.ram_b_addr = dp.ram_b_addr;
  assign bus.ram_b_w    = dp.ram_b_w;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

`ifdef PROG_SEQ_LOOP_EN
  logic [CNT_W-1:0]  loop_n;
  logic [ADDR_W-1:0] stk_top_body;
  logic [CNT_W-1:0]  stk_top_rem;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_clear;
  logic              loop_ok;
  logic              push_c;
  logic              pop_c;
  logic              dec_c;

  assign loop_n    = bus.rom_q[CNT_W-1:0];
  assign stk_clear = (state_q == ST_IDLE) && bus.start;
  assign loop_ok   = (loop_n != '0) && !stk_full;

  always_comb begin
    push_c = 1'b0;
    pop_c  = 1'b0;
    dec_c  = 1'b0;
    if (state_q == ST_RUN) begin
      if (op == OP_LOOP) begin
        push_c = loop_ok;
      end else if (op == OP_ENDLOOP && !stk_empty) begin
        pop_c = (stk_top_rem == '0);
        dec_c = (stk_top_rem != '0);
      end
    end
  end

  seq_loop_stack #(
    .LOOP_DEPTH(LOOP_DEPTH),
    .CNT_W     (CNT_W)
  ) u_loop_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (stk_clear),
    .push     (push_c),
    .pop      (pop_c),
    .dec_top  (dec_c),
    .push_body(addr_inc),
    .push_rem (loop_n - CNT_W'(1)),
    .top_body (stk_top_body),
    .top_rem  (stk_top_rem),
    .full     (stk_full),
    .empty    (stk_empty)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            rom_addr_q <= bus.entry_addr;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (op == OP_HALT) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (is_issue(op)) begin
            if (op == OP_W'(1)) begin
              rom_addr_q <= addr_inc;
            end else begin
              hold_q  <= op - OP_W'(1);
              state_q <= ST_HOLD;
            end
          end else if (op == OP_JUMP) begin
            rom_addr_q <= bus.rom_q[ADDR_W-1:0];
`ifdef PROG_SEQ_LOOP_EN
          end else if (op == OP_LOOP && loop_ok) begin
            rom_addr_q <= addr_inc;
          end else if (op == OP_ENDLOOP && !stk_empty) begin
            rom_addr_q <= (stk_top_rem == '0) ? addr_inc : stk_top_body;
`endif
          end else begin
            // Illegal word or loop fault: abort without a done pulse
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_q == HOLD_W'(1)) begin
            rom_addr_q <= addr_inc;
            state_q    <= ST_RUN;
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
